// File: rtl/seven_seg_scan_driver_pkg.sv
// seven_seg_scan_driver_pkg: shared types, idle levels and hex glyphs for the display driver
package seven_seg_scan_driver_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  typedef enum logic {BLANK, DRIVE} state_t;
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;
endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: valid/ready update channel carrying value, decimal points and blank mask
interface seven_seg_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_value;
  logic [3:0]  upd_dp;
  logic [3:0]  upd_blank;
  modport master (output upd_valid, upd_value, upd_dp, upd_blank, input upd_ready);
  modport slave (input upd_valid, upd_value, upd_dp, upd_blank, output upd_ready);
endinterface

// File: rtl/seven_seg_scan_driver_hex.sv
// hex_to_seg7: nibble to active-high a..g segment pattern, full hex 0-F
module hex_to_seg7
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // glyph lookup
  always_comb begin
    seg = GLYPH_0;
    case (nib)
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = GLYPH_0;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: 4-digit multiplexed seven-segment scanner with blanking gap and frame-aligned updates
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  seven_seg_if.slave upd,
  output logic       frame_done,
  output logic [7:0] io_seg,
  output logic [3:0] io_sel
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] idx;
  state_t state, state_nx;
  disp_t disp, pend;
  logic pend_full, xfer, lit;
  logic [3:0] nib;
  logic [6:0] glyph;
  assign frame_done = idx == 2'd3 && cnt == LAST;
  assign upd.upd_ready = ~pend_full;
  assign xfer = upd.upd_valid && !pend_full;
  assign nib = disp.value[{idx, 2'b00} +: 4];
  assign lit = state == DRIVE && !disp.blank[idx];
  hex_to_seg7 u_hex (.nib(nib), .seg(glyph));
  // next slot position and whether it falls in the blanking gap
  always_comb begin
    cnt_nx = cnt == LAST ? '0 : cnt + 1'b1;
    state_nx = cnt_nx < CW'(BLANK_CYCLES) ? BLANK : DRIVE;
  end
  // slot counter, digit index and scan state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      state <= BLANK;
    end else begin
      cnt <= cnt_nx;
      idx <= cnt == LAST ? idx + 2'd1 : idx;
      state <= state_nx;
    end
  end
  // registered pins so no input reaches io_* combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_seg <= SEG_OFF;
      io_sel <= SEL_OFF;
    end else begin
      io_seg <= lit ? ~{disp.dp[idx], glyph} : SEG_OFF;
      io_sel <= lit ? ~(4'b1 << idx) : SEL_OFF;
    end
  end
  // update handshake; display only changes on a frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp <= '0;
      pend <= '0;
      pend_full <= 1'b0;
    end else if (frame_done) begin
      if (pend_full) disp <= pend;
      else if (xfer) disp <= '{upd.upd_value, upd.upd_dp, upd.upd_blank};
      pend_full <= 1'b0;
    end else if (xfer) begin
      pend <= '{upd.upd_value, upd.upd_dp, upd.upd_blank};
      pend_full <= 1'b1;
    end
  end
endmodule
